gpio_bank_apb: RTL and testbench

- APB responder for one GPIO bank of the SPI GPIO expander. One instance hangs off each psel bit of the SPI-to-APB bridge.
- Holds output, direction and edge-interrupt registers, and samples pins through a 2-flop synchronizer.
- Completes each APB transfer with exactly one pready pulse and flags illegal accesses with pslverr.

---
 rtl/gpio_apb_pkg.sv | 19 +
 rtl/gpio_sync2.sv | 28 ++
 rtl/gpio_bank_apb.sv | 129 ++++++++++++
 tb/tb_gpio_bank_apb.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/gpio_apb_pkg.sv
// Shared constants for the APB GPIO bank: register offsets, default widths,
// and the transfer FSM state encoding.
package gpio_apb_pkg;
    localparam int DATA_W_DEF  = 8;
    localparam int ADDR_W_DEF  = 3;

    localparam int ADDR_OUT    = 0;
    localparam int ADDR_DIR    = 1;
    localparam int ADDR_IN     = 2;
    localparam int ADDR_RISE   = 3;
    localparam int ADDR_FALL   = 4;
    localparam int ADDR_STATUS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } state_e;
endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchronizer for asynchronous pad inputs, synchronous active-high reset.
module gpio_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] s1_d, s1_q, s2_d, s2_q;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;
endmodule

// File: rtl/gpio_bank_apb.sv
// APB responder for one GPIO bank: output/direction registers, synchronized
// inputs, per-pin edge interrupts with W1C status, one pready pulse per transfer.
module gpio_bank_apb
    import gpio_apb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W_DEF,
    parameter int ADDR_WIDTH = ADDR_W_DEF
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] gpio_in,
    output logic [DATA_WIDTH-1:0] gpio_out,
    output logic [DATA_WIDTH-1:0] gpio_oe,
    output logic                  irq
);
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] out_q, out_d, dir_q, dir_d;
    logic [DATA_WIDTH-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [DATA_WIDTH-1:0] status_q, status_d, prev_q, prev_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
    logic                  pready_q, pready_d, pslverr_q, pslverr_d, irq_q, irq_d;
    logic [DATA_WIDTH-1:0] sync, rise, fall, clr;
    logic                  access;

    gpio_sync2 #(.WIDTH(DATA_WIDTH)) u_sync (
        .clk (pclk),
        .rst (preset),
        .d   (gpio_in),
        .q   (sync)
    );

    assign rise   = sync & ~prev_q;
    assign fall   = ~sync & prev_q;
    assign access = (state_q == IDLE) && psel && penable;

    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        prdata_d  = prdata_q;
        pslverr_d = pslverr_q;
        pready_d  = access;
        prev_d    = sync;
        irq_d     = |status_q;
        clr       = '0;

        case (state_q)
            IDLE:    if (access) state_d = ACK;
            ACK:     state_d = DONE;
            DONE:    if (!(psel && penable)) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (access) begin
            pslverr_d = 1'b0;
            if (pwrite) begin
                case (paddr)
                    ADDR_WIDTH'(ADDR_OUT):    out_d     = pwdata;
                    ADDR_WIDTH'(ADDR_DIR):    dir_d     = pwdata;
                    ADDR_WIDTH'(ADDR_RISE):   rise_en_d = pwdata;
                    ADDR_WIDTH'(ADDR_FALL):   fall_en_d = pwdata;
                    ADDR_WIDTH'(ADDR_STATUS): clr       = pwdata;
                    default:                  pslverr_d = 1'b1;
                endcase
            end else begin
                case (paddr)
                    ADDR_WIDTH'(ADDR_OUT):    prdata_d = out_q;
                    ADDR_WIDTH'(ADDR_DIR):    prdata_d = dir_q;
                    ADDR_WIDTH'(ADDR_IN):     prdata_d = sync;
                    ADDR_WIDTH'(ADDR_RISE):   prdata_d = rise_en_q;
                    ADDR_WIDTH'(ADDR_FALL):   prdata_d = fall_en_q;
                    ADDR_WIDTH'(ADDR_STATUS): prdata_d = status_q;
                    default: begin
                        prdata_d  = '0;
                        pslverr_d = 1'b1;
                    end
                endcase
            end
        end

        // New edges are OR-ed in after the clear so a same-cycle set survives.
        status_d = (status_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= IDLE;
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= prev_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            irq_q     <= irq_d;
        end
    end

    assign prdata   = prdata_q;
    assign pready   = pready_q;
    assign pslverr  = pslverr_q;
    assign irq      = irq_q;
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
endmodule

// File: tb/tb_gpio_bank_apb.sv
// Directed bench for gpio_bank_apb: register table plus hand-timed sequences
// for held penable, edge latency, W1C collision and reset abort.
module tb_gpio_bank_apb;
    logic       pclk = 1'b0;
    logic       preset, psel, penable, pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata, prdata, gpio_in, gpio_out, gpio_oe;
    logic       pready, pslverr, irq;

    int n_checks = 0;
    int n_fail   = 0;
    int pready_cnt = 0;

    gpio_bank_apb #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .pclk     (pclk),
        .preset   (preset),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .gpio_in  (gpio_in),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .irq      (irq)
    );

    always #5 pclk = ~pclk;

    always @(negedge pclk) if (pready === 1'b1) pready_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apb(input logic wr, input logic [2:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic err);
        logic got;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge pclk); #1;
            if (pready === 1'b1) got = 1'b1;
        end
        rd = prdata;
        err = pslverr;
        psel = 1'b0; penable = 1'b0;
        if (!got) check("apb_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic       wr;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp_rd;
        logic       exp_err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        logic [7:0] rd;
        logic       er;
        int         c0;

        vecs[0]  = '{1'b1, 3'd0, 8'hA5, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 8'h0F, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 8'h00, 8'hA5, 1'b0};
        vecs[3]  = '{1'b0, 3'd1, 8'h00, 8'h0F, 1'b0};
        vecs[4]  = '{1'b1, 3'd3, 8'h01, 8'h00, 1'b0};
        vecs[5]  = '{1'b1, 3'd4, 8'h80, 8'h00, 1'b0};
        vecs[6]  = '{1'b0, 3'd3, 8'h00, 8'h01, 1'b0};
        vecs[7]  = '{1'b0, 3'd4, 8'h00, 8'h80, 1'b0};
        vecs[8]  = '{1'b1, 3'd2, 8'h55, 8'h00, 1'b1};
        vecs[9]  = '{1'b0, 3'd2, 8'h00, 8'h00, 1'b0};
        vecs[10] = '{1'b0, 3'd6, 8'h00, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 3'd7, 8'h00, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 3'd5, 8'h00, 8'h00, 1'b0};

        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; gpio_in = 8'h00;

        // Reset and idle
        repeat (2) @(posedge pclk);
        #1;
        check("rst_prdata",  32'(prdata), 32'h0);
        check("rst_pready",  32'(pready), 32'h0);
        check("rst_pslverr", 32'(pslverr), 32'h0);
        check("rst_irq",     32'(irq), 32'h0);
        check("rst_out",     32'(gpio_out), 32'h0);
        check("rst_oe",      32'(gpio_oe), 32'h0);
        check("rst_state",   32'(dut.state_q), 32'd0);
        preset = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        check("idle_no_pready", 32'(pready_cnt), 32'd0);

        // Register table
        c0 = pready_cnt;
        for (int i = 0; i < 13; i++) begin
            apb(vecs[i].wr, vecs[i].a, vecs[i].d, rd, er);
            check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp_rd));
        end
        repeat (2) @(posedge pclk);
        #1;
        check("table_pready_pulses", 32'(pready_cnt - c0), 32'd13);
        check("gpio_out_a5", 32'(gpio_out), 32'hA5);
        check("gpio_oe_0f",  32'(gpio_oe), 32'h0F);

        // Held penable: one pulse, FSM parks in DONE
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h3C;
        @(posedge pclk); #1;
        penable = 1'b1;
        c0 = pready_cnt;
        repeat (5) @(posedge pclk);
        #1;
        check("held_pulses", 32'(pready_cnt - c0), 32'd1);
        check("held_state_done", 32'(dut.state_q), 32'd2);
        check("held_out", 32'(gpio_out), 32'h3C);
        penable = 1'b0; psel = 1'b0;
        @(posedge pclk); #1;
        check("held_state_idle", 32'(dut.state_q), 32'd0);

        // Edge interrupt latency: rise on bit0
        gpio_in = 8'h81;
        repeat (2) @(posedge pclk);
        #1;
        check("edge_status_e2", 32'(dut.status_q), 32'h00);
        @(posedge pclk); #1;
        check("edge_status_e3", 32'(dut.status_q), 32'h01);
        check("edge_irq_e3", 32'(irq), 32'h0);
        @(posedge pclk); #1;
        check("edge_irq_e4", 32'(irq), 32'h1);

        gpio_in = 8'h01;
        repeat (3) @(posedge pclk);
        #1;
        check("fall_status", 32'(dut.status_q), 32'h81);
        apb(1'b0, 3'd5, 8'h00, rd, er);
        check("status_read", 32'(rd), 32'h81);
        check("status_read_noclr", 32'(dut.status_q), 32'h81);
        apb(1'b1, 3'd5, 8'h01, rd, er);
        check("w1c_01_status", 32'(dut.status_q), 32'h80);
        check("w1c_01_irq", 32'(irq), 32'h1);
        apb(1'b1, 3'd5, 8'h80, rd, er);
        check("w1c_80_status", 32'(dut.status_q), 32'h00);
        check("w1c_80_irq_hold", 32'(irq), 32'h1);
        @(posedge pclk); #1;
        check("w1c_80_irq_low", 32'(irq), 32'h0);

        // Set/clear collision on bit0
        gpio_in = 8'h00;
        repeat (5) @(posedge pclk);
        #1;
        gpio_in = 8'h01;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd5; pwdata = 8'h01;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check("coll_pready", 32'(pready), 32'h1);
        check("coll_status", 32'(dut.status_q), 32'h01);
        psel = 1'b0; penable = 1'b0;
        apb(1'b1, 3'd5, 8'h01, rd, er);
        check("coll_cleared", 32'(dut.status_q), 32'h00);

        // Reset while in ACK
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'hFF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check("abort_pready_ack", 32'(pready), 32'h1);
        check("abort_out_ff", 32'(gpio_out), 32'hFF);
        preset = 1'b1; psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        check("abort_pready", 32'(pready), 32'h0);
        check("abort_out", 32'(gpio_out), 32'h00);
        check("abort_state", 32'(dut.state_q), 32'd0);
        preset = 1'b0;
        repeat (2) @(posedge pclk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
